// File: rtl/driver7seg_mux.sv
// driver7seg_mux: time-multiplexed driver for N_DIGITS common-anode
// seven-segment digits.
//
// A prescaler divides each digit slot into REFRESH_DIV cycles. The first
// DEAD_CYC cycles of every slot keep all anodes off to avoid ghosting.
// The display data is sampled once per frame, at the start of digit 0's
// slot, so a frame never mixes old and new values.
//
// The anodes and segments are active-low and registered. They have one
// cycle of latency from the internal state.
//
// Optional build macro: DRIVER7SEG_LZB_EN enables leading-zero blanking.
// When it is undefined, no suppression logic is built.
module driver7seg_mux #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYC    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*N_DIGITS-1:0] valor_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic                  blank_i,
  output logic [N_DIGITS-1:0]   anodos_o,
  output logic [7:0]            segmentos_o
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_DEAD = PRE_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [PRE_W-1:0]      pre_cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] snap;
  logic [N_DIGITS-1:0]   dp_snap;

  logic                  tc;
  logic                  frame_start;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic [7:0]            glyph;
  logic                  suppress;
  logic                  digit_on;
  logic [N_DIGITS-1:0]   an_next;
  logic [7:0]            seg_next;

  // Slot timing decode and selection of the current digit's data
  always_comb begin
    tc          = (pre_cnt == PRE_LAST);
    frame_start = (pre_cnt == '0) && (idx == '0);
    cur_nib     = snap[{idx, 2'b00} +: 4];
    cur_dp      = dp_snap[idx];
  end

  // Hex nibble to active-low {a,b,c,d,e,f,g} pattern, with the dp bit off
  always_comb begin
    glyph = 8'hFF;
    case (cur_nib)
      4'h0: glyph = 8'h03;
      4'h1: glyph = 8'h9F;
      4'h2: glyph = 8'h25;
      4'h3: glyph = 8'h0D;
      4'h4: glyph = 8'h99;
      4'h5: glyph = 8'h49;
      4'h6: glyph = 8'h41;
      4'h7: glyph = 8'h1F;
      4'h8: glyph = 8'h01;
      4'h9: glyph = 8'h09;
      4'hA: glyph = 8'h11;
      4'hB: glyph = 8'hC1;
      4'hC: glyph = 8'h63;
      4'hD: glyph = 8'h85;
      4'hE: glyph = 8'h61;
      4'hF: glyph = 8'h71;
      default: glyph = 8'hFF;
    endcase
  end

`ifdef DRIVER7SEG_LZB_EN
  // Leading-zero blanking: hide digit k > 0 when it and every more
  // significant digit hold zero with no decimal point lit. A lit point
  // above keeps the zeros below it visible, so 0005 with dp on digit 2
  // reads "0.05" rather than "0. 5". Digit 0 is never hidden.
  always_comb begin
    logic upper_dark;
    suppress   = 1'b0;
    upper_dark = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      upper_dark = upper_dark & (snap[4*k +: 4] == 4'h0) & ~dp_snap[k];
      if (idx == IDX_W'(k)) suppress = upper_dark;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  // Next output values: the segments always follow the current digit,
  // and only the anode enable gates visibility
  always_comb begin
    digit_on     = (pre_cnt >= PRE_DEAD) && !blank_i && !suppress;
    an_next      = '1;
    if (digit_on) an_next[idx] = 1'b0;
    seg_next     = {glyph[7:1], glyph[0] & ~cur_dp};
  end

  // Prescaler, digit index, frame snapshot and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_cnt     <= '0;
      idx         <= '0;
      snap        <= '0;
      dp_snap     <= '0;
      anodos_o    <= '1;
      segmentos_o <= 8'hFF;
    end else begin
      pre_cnt <= tc ? '0 : pre_cnt + PRE_W'(1);
      if (tc) idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      if (frame_start) begin
        snap    <= valor_i;
        dp_snap <= dp_i;
      end
      anodos_o    <= an_next;
      segmentos_o <= seg_next;
    end
  end

endmodule

// File: tb/tb_driver7seg_mux.sv
// Bench for driver7seg_mux with N_DIGITS=4, REFRESH_DIV=8 and DEAD_CYC=2.
// The reference model works from the number of edges since reset release.
// From that count it derives the slot phase, the digit and the frame with
// plain arithmetic. It keeps the value captured at each frame start in an
// array indexed by frame number.
module tb_driver7seg_mux;

  localparam int N   = 4;
  localparam int RD  = 8;
  localparam int DC  = 2;
  localparam int FRM = N * RD;
  localparam int MAX_FRAMES = 512;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [15:0] valor_i;
  logic [3:0]  dp_i;
  logic        blank_i;
  logic [3:0]  anodos_o;
  logic [7:0]  segmentos_o;

  // Clock generation
  always #5 clk = ~clk;

  driver7seg_mux #(
    .N_DIGITS   (N),
    .REFRESH_DIV(RD),
    .DEAD_CYC   (DC)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .valor_i    (valor_i),
    .dp_i       (dp_i),
    .blank_i    (blank_i),
    .anodos_o   (anodos_o),
    .segmentos_o(segmentos_o)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int e        = 0;

  logic [15:0] cap_val [MAX_FRAMES];
  logic [3:0]  cap_dp  [MAX_FRAMES];
  logic [7:0]  glyph_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49,
                                  8'h41, 8'h1F, 8'h01, 8'h09, 8'h11, 8'hC1,
                                  8'h63, 8'h85, 8'h61, 8'h71};

  task automatic check_reset();
    @(posedge clk);
    @(negedge clk);
    n_assert++;
    assert (anodos_o === 4'hF) else begin
      n_fail++;
      $error("FAIL rst_anodos got %h exp %h", anodos_o, 4'hF);
    end
    n_assert++;
    assert (segmentos_o === 8'hFF) else begin
      n_fail++;
      $error("FAIL rst_segmentos got %h exp %h", segmentos_o, 8'hFF);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_i = 1'b1;
    repeat (cycles) check_reset();
    rst_i = 1'b0;
    e     = 0;
  endtask

  // One clock edge. The expected outputs are computed from the inputs
  // held before the edge and from the edge count.
  task automatic step();
    int          pre;
    int          d;
    int          f;
    int          nib;
    logic [15:0] v;
    logic [3:0]  p;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_an;
    bit          en;
    pre = e % RD;
    d   = (e / RD) % N;
    f   = (e / FRM) % MAX_FRAMES;
    if (pre == 0 && d == 0) begin
      cap_val[f] = valor_i;
      cap_dp[f]  = dp_i;
      if (e == 0) begin
        v = 16'h0;
        p = 4'h0;
      end else begin
        v = cap_val[(f + MAX_FRAMES - 1) % MAX_FRAMES];
        p = cap_dp[(f + MAX_FRAMES - 1) % MAX_FRAMES];
      end
    end else begin
      v = cap_val[f];
      p = cap_dp[f];
    end
    nib     = int'((v >> (4 * d)) & 16'hF);
    exp_seg = glyph_tab[nib];
    if (p[d]) exp_seg[0] = 1'b0;
    en = (pre >= DC) && !blank_i;
`ifdef DRIVER7SEG_LZB_EN
    if (d > 0 && (v >> (4 * d)) == 16'h0 && (p >> d) == 4'h0) en = 1'b0;
`endif
    exp_an = 4'hF;
    if (en) exp_an[d] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_assert++;
    assert (anodos_o === exp_an) else begin
      n_fail++;
      $error("FAIL anodos e=%0d got %b exp %b", e, anodos_o, exp_an);
    end
    n_assert++;
    assert (segmentos_o === exp_seg) else begin
      n_fail++;
      $error("FAIL segmentos e=%0d got %h exp %h", e, segmentos_o, exp_seg);
    end
    e++;
  endtask

  task automatic run(input int cycles);
    repeat (cycles) step();
  endtask

  // Advance until the edge count reaches the given phase within a frame
  task automatic run_to_phase(input int phase);
    while ((e % FRM) != phase) step();
  endtask

  // Directed sequence followed by random stimulus
  initial begin
    rst_i   = 1'b1;
    valor_i = 16'h0;
    dp_i    = 4'h0;
    blank_i = 1'b0;
    @(negedge clk);

    // Reset held for three cycles
    do_reset(3);

    // Static value, two full frames
    valor_i = 16'h1234;
    run(2 * FRM);

    // Change the value during digit 2's slot: no tearing
    run_to_phase(2 * RD + 3);
    valor_i = 16'hABCD;
    run_to_phase(0);
    run(FRM + 1);

    // Blank for three cycles in the middle of a slot
    run_to_phase(RD + 3);
    blank_i = 1'b1;
    run(3);
    blank_i = 1'b0;
    run_to_phase(0);

    // Decimal point on digit 2 with all zeros
    valor_i = 16'h0000;
    dp_i    = 4'b0100;
    run(2 * FRM);

    // Leading-zero cases (hidden digits only when the macro is set)
    dp_i    = 4'h0;
    valor_i = 16'h0005;
    run(2 * FRM);
    valor_i = 16'h0000;
    run(2 * FRM);
    valor_i = 16'h0005;
    dp_i    = 4'b0100;
    run(2 * FRM);

    // Reset in the middle of a frame
    run_to_phase(2 * RD + 5);
    do_reset(1);
    valor_i = 16'h9F60;
    dp_i    = 4'b1001;
    run(2 * FRM);

    // Random data, points and occasional blanking
    for (int i = 0; i < 20 * FRM; i++) begin
      if ($urandom_range(0, 15) == 0) valor_i = 16'($urandom);
      if ($urandom_range(0, 15) == 0) dp_i = 4'($urandom);
      if ($urandom_range(0, 31) == 0) valor_i = 16'($urandom_range(0, 255));
      blank_i = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
